// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at launch,
// held in temporaries for the programmed latency, then committed to HI/LO.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        RdSel,
    input  logic        D_md,
    output logic        Start,
    output logic        Busy,
    output logic        Stall_MD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmp_hi_q, tmp_hi_d;
    logic [31:0] tmp_lo_q, tmp_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        skip_q, skip_d;

    logic        is_md;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, dvd, dvs, uq, ur;
    logic [31:0] sq, sr;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign abs_a = A[31] ? (~A + 32'd1) : A;
    assign abs_b = B[31] ? (~B + 32'd1) : B;
    assign dvd   = (MDOp == 3'd3) ? abs_a : A;
    assign dvs   = (MDOp == 3'd3) ? abs_b : B;
    assign uq    = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    assign ur    = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
    assign sq    = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
    assign sr    = A[31] ? (~ur + 32'd1) : ur;

    assign is_md    = (MDOp >= 3'd1) && (MDOp <= 3'd4);
    assign Busy     = (state_q == StRun);
    assign Start    = is_md && !Busy;
    assign Stall_MD = D_md & (Start | Busy);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign MDOut    = RdSel ? hi_q : lo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        skip_d   = skip_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StRun;
                    skip_d  = 1'b0;
                    case (MDOp)
                        3'd1: begin
                            {tmp_hi_d, tmp_lo_d} = prod_s;
                            cnt_d = MULT_CYCLES;
                        end
                        3'd2: begin
                            {tmp_hi_d, tmp_lo_d} = prod_u;
                            cnt_d = MULT_CYCLES;
                        end
                        3'd3: begin
                            tmp_hi_d = sr;
                            tmp_lo_d = sq;
                            skip_d   = (B == 32'd0);
                            cnt_d    = DIV_CYCLES;
                        end
                        default: begin
                            tmp_hi_d = ur;
                            tmp_lo_d = uq;
                            skip_d   = (B == 32'd0);
                            cnt_d    = DIV_CYCLES;
                        end
                    endcase
                end else if (MDOp == 3'd5) begin
                    hi_d = A;
                end else if (MDOp == 3'd6) begin
                    lo_d = A;
                end
            end
            StRun: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = StIdle;
                    if (!skip_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            skip_q   <= skip_d;
        end
    end

endmodule
